// File: rtl/prio_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : prio_grant_scheduler
// Purpose  : 8-requester scheduler for one shared resource. Lowest priority
//            value wins. Ties are broken round-robin and long-waiting
//            requesters are promoted. The grant is held until the owner
//            releases it or its tenure of MAX_HOLD cycles expires.
// Revision : 1.0 - initial release
// ============================================================================
module prio_grant_scheduler #(
    parameter int N            = 8,
    parameter int MAX_HOLD     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     req,
    input  logic [8*N-1:0] prio,
    output logic [7:0]     gnt,
    output logic           gnt_valid,
    output logic [2:0]     gnt_idx,
    output logic           revoke
);

    // Width of the tenure counter; it only needs to reach MAX_HOLD-1.
    localparam int              c_HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [3:0]      c_STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [3:0]      c_STARVE_MAX = 4'd15;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [2:0]            r_gnt_idx;
    logic [2:0]            r_last_idx;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [3:0]            r_starve [8];
    logic                  r_revoke;

    logic [7:0]            w_cand;
    logic [7:0]            w_starved;
    logic [7:0]            w_pool;
    logic [7:0]            w_match;
    logic [N-1:0]          w_min;
    logic [2:0]            w_scan;
    logic [2:0]            w_win_idx;
    logic                  w_found;
    logic [2:0]            w_next_owner;
    logic                  w_event;
    logic                  w_timeout;
    logic                  w_go_idle;
    logic                  w_hold_inc;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------

    // Starved candidates form an exclusive pool that outranks every other.
    always_comb begin
        w_starved = '0;
        for (int i = 0; i < 8; i++) begin
            w_starved[i] = (r_starve[i] >= c_STARVE_LIM);
        end
        if ((w_cand & w_starved) != 8'd0) begin
            w_pool = w_cand & w_starved;
        end else begin
            w_pool = w_cand;
        end
    end

    // Smallest priority value present in the pool.
    always_comb begin
        w_min = '1;
        for (int i = 0; i < 8; i++) begin
            if (w_pool[i] && (prio[i*N +: N] < w_min)) begin
                w_min = prio[i*N +: N];
            end
        end
    end

    // Among pool members holding the minimum, take the first one found
    // scanning upward from the slot after the previous winner.
    always_comb begin
        w_match   = '0;
        w_win_idx = 3'd0;
        w_found   = 1'b0;
        w_scan    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_match[i] = w_pool[i] && (prio[i*N +: N] == w_min);
        end
        for (int k = 0; k < 8; k++) begin
            w_scan = r_last_idx + 3'd1 + 3'(k);
            if (!w_found && w_match[w_scan]) begin
                w_win_idx = w_scan;
                w_found   = 1'b1;
            end
        end
    end

    // An empty candidate set only happens on a timeout with nobody else
    // waiting; the current owner then keeps the resource.
    always_comb begin
        w_next_owner = (w_cand == 8'd0) ? r_gnt_idx : w_win_idx;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-edge decisions: arbitrate, time out, release, or hold.
    always_comb begin
        w_state_nxt = r_state;
        w_cand      = '0;
        w_event     = 1'b0;
        w_timeout   = 1'b0;
        w_go_idle   = 1'b0;
        w_hold_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req != 8'd0) begin
                    w_cand      = req;
                    w_event     = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req[r_gnt_idx]) begin
                    // Owner released; hand off directly if anyone else waits.
                    if (req != 8'd0) begin
                        w_cand  = req;
                        w_event = 1'b1;
                    end else begin
                        w_go_idle   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    // Tenure expired: re-arbitrate without the owner.
                    w_cand    = req & ~(8'b1 << r_gnt_idx);
                    w_event   = 1'b1;
                    w_timeout = 1'b1;
                end else begin
                    w_hold_inc = 1'b1;
                end
            end
            default: begin
                w_go_idle   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Owner index, round-robin pointer, tenure counter and revoke pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_idx  <= 3'd0;
            r_last_idx <= 3'd7;
            r_hold_cnt <= '0;
            r_revoke   <= 1'b0;
        end else begin
            r_revoke <= w_timeout;
            if (w_event) begin
                r_gnt_idx  <= w_next_owner;
                r_last_idx <= w_next_owner;
                r_hold_cnt <= '0;
            end else if (w_go_idle) begin
                r_gnt_idx  <= 3'd0;
                r_hold_cnt <= '0;
            end else if (w_hold_inc) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
            end
        end
    end

    // Starvation counters: losers of an arbitration count up, winner and
    // idle requesters reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_starve[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!req[i]) begin
                    r_starve[i] <= 4'd0;
                end else if (w_event) begin
                    if (3'(i) == w_next_owner) begin
                        r_starve[i] <= 4'd0;
                    end else if (r_starve[i] != c_STARVE_MAX) begin
                        r_starve[i] <= r_starve[i] + 4'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Grant vector is derived from the held owner so it is one-hot or zero.
    always_comb begin
        gnt_valid = (r_state == ST_GRANT);
        gnt       = gnt_valid ? (8'b1 << r_gnt_idx) : 8'd0;
        gnt_idx   = r_gnt_idx;
        revoke    = r_revoke;
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_grant_scheduler
// Purpose  : Directed bench for prio_grant_scheduler with a behavioural
//            reference model compared every cycle, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_grant_scheduler;

    localparam int N  = 8;
    localparam int MH = 4;
    localparam int SL = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     req = 8'd0;
    logic [8*N-1:0] prio = '0;
    logic [7:0]     gnt;
    logic           gnt_valid;
    logic [2:0]     gnt_idx;
    logic           revoke;

    int total = 0;
    int bad   = 0;

    prio_grant_scheduler #(
        .N            (N),
        .MAX_HOLD     (MH),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .prio      (prio),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .revoke    (revoke)
    );

    always #5 clk = ~clk;

    // Reference model state: owner is -1 when idle.
    int m_owner  = -1;
    int m_last   = 7;
    int m_hold   = 0;
    int m_starve [8] = '{default: 0};
    bit m_revoke = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Best requester in cand: starved ones only if any exist, then lowest
    // prio, then smallest clockwise distance from the slot after m_last.
    function automatic int pick(input logic [7:0] cand);
        int  best;
        int  best_p;
        int  best_d;
        int  p;
        int  d;
        bit  any_st;
        best   = -1;
        best_p = 0;
        best_d = 0;
        any_st = 1'b0;
        for (int i = 0; i < 8; i++)
            if (cand[i] && m_starve[i] >= SL) any_st = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (cand[i] && (!any_st || m_starve[i] >= SL)) begin
                p = int'(prio[i*N +: N]);
                d = (i - m_last - 1 + 16) % 8;
                if (best < 0 || p < best_p || (p == best_p && d < best_d)) begin
                    best   = i;
                    best_p = p;
                    best_d = d;
                end
            end
        end
        return best;
    endfunction

    // Reference model advanced on every rising edge.
    always @(posedge clk or negedge rst_n) begin
        int win;
        logic [7:0] c;
        if (!rst_n) begin
            m_owner  = -1;
            m_last   = 7;
            m_hold   = 0;
            m_revoke = 1'b0;
            for (int i = 0; i < 8; i++) m_starve[i] = 0;
        end else begin
            win      = -1;
            m_revoke = 1'b0;
            if (m_owner < 0) begin
                if (req != 8'd0) win = pick(req);
            end else if (!req[m_owner]) begin
                if (req != 8'd0) win = pick(req);
                else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (m_hold == MH - 1) begin
                c = req;
                c[m_owner] = 1'b0;
                m_revoke = 1'b1;
                win = (c == 8'd0) ? m_owner : pick(c);
            end else begin
                m_hold++;
            end
            for (int i = 0; i < 8; i++) begin
                if (!req[i]) m_starve[i] = 0;
                else if (win >= 0) begin
                    if (i == win) m_starve[i] = 0;
                    else if (m_starve[i] < 15) m_starve[i]++;
                end
            end
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                m_hold  = 0;
            end
        end
    end

    // Compare DUT against the model every falling edge.
    always @(negedge clk) begin
        chk("cyc_gnt",       int'(gnt),       (m_owner < 0) ? 0 : (1 << m_owner));
        chk("cyc_gnt_valid", int'(gnt_valid), (m_owner < 0) ? 0 : 1);
        chk("cyc_gnt_idx",   int'(gnt_idx),   (m_owner < 0) ? 0 : m_owner);
        chk("cyc_revoke",    int'(revoke),    int'(m_revoke));
        chk("cyc_onehot",    int'($onehot0(gnt)), 1);
        chk("cyc_gnt_at_idx", int'(gnt[gnt_idx]), int'(gnt_valid));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_prio(input int i, input int v);
        prio[i*N +: N] = N'(v);
    endtask

    task automatic do_reset();
        req   = 8'd0;
        prio  = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_idx", int'(gnt_idx), 0);
        chk("rst_revoke", int'(revoke), 0);
        rst_n = 1'b1;

        // Basic lowest-value select, hold, prio change ignored, idle return
        set_prio(1, 5);
        set_prio(2, 3);
        set_prio(4, 9);
        req = 8'b0001_0110;
        tick();
        chk("basic_gnt", int'(gnt), 8'h04);
        chk("basic_idx", int'(gnt_idx), 2);
        set_prio(2, 200);
        tick();
        tick();
        chk("basic_hold_idx", int'(gnt_idx), 2);
        req = 8'd0;
        tick();
        chk("idle_valid", int'(gnt_valid), 0);
        chk("idle_idx", int'(gnt_idx), 0);

        // Equal-priority round-robin with back-to-back handoff
        do_reset();
        for (int i = 0; i < 8; i++) set_prio(i, 7);
        req = 8'hFF;
        tick();
        chk("rr_first", int'(gnt_idx), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_hold", int'(gnt_idx), k);
            req = 8'hFF & ~(8'd1 << k);
            tick();
            chk("rr_next", int'(gnt_idx), (k + 1) % 8);
            chk("rr_no_gap", int'(gnt_valid), 1);
            req = 8'hFF;
        end
        req = 8'd0;
        tick();

        // Tenure timeout: self-regrant, then handoff to a waiter
        do_reset();
        set_prio(0, 0);
        req = 8'h01;
        tick();
        chk("to_grant", int'(gnt_idx), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_no_revoke", int'(revoke), 0);
        end
        tick();
        chk("to_revoke", int'(revoke), 1);
        chk("to_regrant", int'(gnt), 8'h01);
        set_prio(3, 1);
        req = 8'h09;
        tick();
        chk("to_pulse_end", int'(revoke), 0);
        tick();
        tick();
        chk("to_still0", int'(gnt_idx), 0);
        tick();
        chk("to_move3", int'(gnt_idx), 3);
        chk("to_revoke2", int'(revoke), 1);
        req = 8'd0;
        tick();

        // Starvation promotion of a low-priority requester
        do_reset();
        set_prio(0, 1);
        set_prio(1, 1);
        set_prio(5, 200);
        req = 8'h21; tick(); chk("st_a", int'(gnt_idx), 0);
        req = 8'h22; tick(); chk("st_b", int'(gnt_idx), 1);
        req = 8'h21; tick(); chk("st_c", int'(gnt_idx), 0);
        req = 8'h22; tick(); chk("st_d", int'(gnt_idx), 1);
        req = 8'h21; tick(); chk("st_promote", int'(gnt_idx), 5);
        req = 8'h22; tick(); chk("st_keep", int'(gnt_idx), 5);
        req = 8'h02; tick(); chk("st_after", int'(gnt_idx), 1);
        req = 8'd0;
        tick();

        // Asynchronous reset mid-grant, then round-robin restarts at 0
        do_reset();
        req = 8'h40;
        tick();
        chk("ar_idx6", int'(gnt_idx), 6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", int'(gnt), 0);
        chk("ar_valid", int'(gnt_valid), 0);
        req = 8'h81;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_rr0", int'(gnt), 8'h01);
        req = 8'd0;
        tick();
        chk("ar_idle", int'(gnt_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
